// File: rtl/axi_pkg.sv
// Shared AXI4 definitions for the burst master: burst/response codes, the
// controller state encoding and the 4 KB boundary check.
package axi_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_AW,
      S_W,
      S_B,
      S_AR,
      S_R,
      S_DONE
   } state_e;

   // Only the offset inside the current 4 KB page matters for the crossing test.
   function automatic logic crosses_4k(input logic [11:0] addr,
                                       input logic [7:0]  len,
                                       input int unsigned strb_width);
      int unsigned span;
      span = 32'(addr) + (32'(len) + 32'd1) * strb_width;
      return span > 32'd4096;
   endfunction

   function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 INCR burst master: one command at a time is turned
// into an AW/W/B or AR/R transaction with a one-cycle completion pulse.
module axi_burst_master
   import axi_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int ID_WIDTH   = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [7:0]            cmd_len,
   input  logic [ID_WIDTH-1:0]   cmd_id,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [STRB_WIDTH-1:0] wr_strb,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_last,
   output logic [1:0]            rd_resp,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic                  done_valid,
   output logic                  done_write,
   output logic [ID_WIDTH-1:0]   done_id,
   output logic [1:0]            done_resp,
   output logic [ID_WIDTH-1:0]   m_axi_awid,
   output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic [7:0]            m_axi_awlen,
   output logic [2:0]            m_axi_awsize,
   output logic [1:0]            m_axi_awburst,
   output logic                  m_axi_awlock,
   output logic [3:0]            m_axi_awcache,
   output logic [2:0]            m_axi_awprot,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   output logic [DATA_WIDTH-1:0] m_axi_wdata,
   output logic [STRB_WIDTH-1:0] m_axi_wstrb,
   output logic                  m_axi_wlast,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   input  logic [ID_WIDTH-1:0]   m_axi_bid,
   input  logic [1:0]            m_axi_bresp,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready,
   output logic [ID_WIDTH-1:0]   m_axi_arid,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]            m_axi_arlen,
   output logic [2:0]            m_axi_arsize,
   output logic [1:0]            m_axi_arburst,
   output logic                  m_axi_arlock,
   output logic [3:0]            m_axi_arcache,
   output logic [2:0]            m_axi_arprot,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [ID_WIDTH-1:0]   m_axi_rid,
   input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rlast,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready
);

   localparam logic [2:0]            AxSize   = 3'($clog2(STRB_WIDTH));
   localparam logic [ADDR_WIDTH-1:0] AddrMask = ~ADDR_WIDTH'(STRB_WIDTH - 1);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]            len_q, len_d;
   logic [ID_WIDTH-1:0]   id_q, id_d;
   logic                  write_q, write_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [1:0]            resp_q, resp_d;

   logic [ADDR_WIDTH-1:0] cmd_addr_aligned;
   logic                  beat_last;
   logic [1:0]            r_merged;
   logic [1:0]            r_status;
   logic                  unused_rid;

   assign cmd_addr_aligned = cmd_addr & AddrMask;
   assign beat_last        = (cnt_q == len_q);
   // Read responses are sticky-worst; an rlast out of step with the beat count is at least SLVERR.
   assign r_merged         = resp_worst(resp_q, m_axi_rresp);
   assign r_status         = (m_axi_rlast != beat_last) ? resp_worst(r_merged, RESP_SLVERR) : r_merged;
   assign unused_rid       = ^m_axi_rid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         id_q    <= '0;
         write_q <= 1'b0;
         cnt_q   <= '0;
         resp_q  <= RESP_OKAY;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         id_q    <= id_d;
         write_q <= write_d;
         cnt_q   <= cnt_d;
         resp_q  <= resp_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      len_d   = len_q;
      id_d    = id_q;
      write_d = write_q;
      cnt_d   = cnt_q;
      resp_d  = resp_q;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               addr_d  = cmd_addr_aligned;
               len_d   = cmd_len;
               id_d    = cmd_id;
               write_d = cmd_write;
               cnt_d   = '0;
               resp_d  = RESP_OKAY;
               if (crosses_4k(cmd_addr_aligned[11:0], cmd_len, STRB_WIDTH)) begin
                  resp_d  = RESP_SLVERR;
                  state_d = S_DONE;
               end else begin
                  state_d = cmd_write ? S_AW : S_AR;
               end
            end
         end
         S_AW: if (m_axi_awready) state_d = S_W;
         S_W: begin
            if (wr_valid && m_axi_wready) begin
               cnt_d = cnt_q + 8'd1;
               if (beat_last) begin
                  cnt_d   = '0;
                  state_d = S_B;
               end
            end
         end
         S_B: begin
            if (m_axi_bvalid) begin
               resp_d  = (m_axi_bid != id_q) ? RESP_SLVERR : m_axi_bresp;
               state_d = S_DONE;
            end
         end
         S_AR: if (m_axi_arready) state_d = S_R;
         S_R: begin
            if (m_axi_rvalid && rd_ready) begin
               resp_d = r_status;
               cnt_d  = cnt_q + 8'd1;
               if (beat_last) begin
                  cnt_d   = '0;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Handshake outputs decode straight from the state so a reset drops them at once.
   always_comb begin
      cmd_ready     = 1'b0;
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      wr_ready      = 1'b0;
      m_axi_bready  = 1'b0;
      m_axi_arvalid = 1'b0;
      rd_valid      = 1'b0;
      m_axi_rready  = 1'b0;
      done_valid    = 1'b0;
      unique case (state_q)
         S_IDLE: cmd_ready = 1'b1;
         S_AW:   m_axi_awvalid = 1'b1;
         S_W: begin
            m_axi_wvalid = wr_valid;
            wr_ready     = m_axi_wready;
         end
         S_B:    m_axi_bready = 1'b1;
         S_AR:   m_axi_arvalid = 1'b1;
         S_R: begin
            rd_valid     = m_axi_rvalid;
            m_axi_rready = rd_ready;
         end
         S_DONE:  done_valid = 1'b1;
         default: cmd_ready = 1'b0;
      endcase
   end

   assign m_axi_awid    = id_q;
   assign m_axi_awaddr  = addr_q;
   assign m_axi_awlen   = len_q;
   assign m_axi_awsize  = AxSize;
   assign m_axi_awburst = BURST_INCR;
   assign m_axi_awlock  = 1'b0;
   assign m_axi_awcache = 4'd0;
   assign m_axi_awprot  = 3'd0;

   assign m_axi_arid    = id_q;
   assign m_axi_araddr  = addr_q;
   assign m_axi_arlen   = len_q;
   assign m_axi_arsize  = AxSize;
   assign m_axi_arburst = BURST_INCR;
   assign m_axi_arlock  = 1'b0;
   assign m_axi_arcache = 4'd0;
   assign m_axi_arprot  = 3'd0;

   assign m_axi_wdata   = wr_data;
   assign m_axi_wstrb   = wr_strb;
   assign m_axi_wlast   = beat_last;

   assign rd_data       = m_axi_rdata;
   assign rd_last       = m_axi_rlast;
   assign rd_resp       = m_axi_rresp;

   assign done_write    = write_q;
   assign done_id       = id_q;
   assign done_resp     = resp_q;

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master with a small AXI RAM slave model and
// scoreboard queues for completions and read beats.
module tb_axi_burst_master;
   import axi_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [15:0] cmd_addr;
   logic [7:0]  cmd_len, cmd_id;
   logic [31:0] wr_data;
   logic [3:0]  wr_strb;
   logic        wr_valid, wr_ready;
   logic [31:0] rd_data;
   logic        rd_last, rd_valid, rd_ready;
   logic [1:0]  rd_resp;
   logic        done_valid, done_write;
   logic [7:0]  done_id;
   logic [1:0]  done_resp;
   logic [7:0]  m_axi_awid, m_axi_awlen, m_axi_arid, m_axi_arlen;
   logic [15:0] m_axi_awaddr, m_axi_araddr;
   logic [2:0]  m_axi_awsize, m_axi_awprot, m_axi_arsize, m_axi_arprot;
   logic [1:0]  m_axi_awburst, m_axi_arburst;
   logic        m_axi_awlock, m_axi_arlock;
   logic [3:0]  m_axi_awcache, m_axi_arcache;
   logic        m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
   logic [31:0] m_axi_wdata, m_axi_rdata;
   logic [3:0]  m_axi_wstrb;
   logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
   logic [7:0]  m_axi_bid, m_axi_rid;
   logic [1:0]  m_axi_bresp, m_axi_rresp;
   logic        m_axi_bvalid, m_axi_bready;
   logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

   typedef struct packed {
      logic       wr;
      logic [7:0] id;
      logic [1:0] resp;
   } doneRec_t;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } rdRec_t;

   doneRec_t doneQ[$];
   rdRec_t   rdQ[$];
   doneRec_t doneExp;
   rdRec_t   rdExp;

   int checkTotal = 0, checkPassed = 0, checkFailed = 0;
   int doneCount = 0, doneTarget = 0, awCycles = 0, wCycles = 0;
   logic slaveStall = 1'b0, corruptBid = 1'b0;
   int   badRlastBeat = -1;

   always #5 clk = ~clk;

   axi_burst_master dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
      .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_last(rd_last), .rd_resp(rd_resp),
      .rd_valid(rd_valid), .rd_ready(rd_ready),
      .done_valid(done_valid), .done_write(done_write), .done_id(done_id), .done_resp(done_resp),
      .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
      .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
      .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
      .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkTotal++;
      assert (observed === expected) checkPassed++;
      else begin
         checkFailed++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // RAM slave model: random ready/valid gaps, one cycle of wready wait after AW
   logic [31:0] mem [0:16383];
   logic [13:0] waddr, raddr, wIdx, rIdx;
   logic [7:0]  wlen, rlen, wid, rid, wcnt, rcnt;
   logic        wBusy, rBusy;

   function automatic logic slaveGo();
      return slaveStall ? 1'($urandom_range(1)) : 1'b1;
   endfunction

   assign wIdx        = waddr + 14'(wcnt);
   assign rIdx        = raddr + 14'(rcnt);
   assign m_axi_bresp = RESP_OKAY;
   assign m_axi_rresp = RESP_OKAY;
   assign m_axi_rid   = rid;
   assign m_axi_rdata = mem[rIdx];
   assign m_axi_rlast = (badRlastBeat >= 0) ? (int'(rcnt) == badRlastBeat) : (rcnt == rlen);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_axi_awready <= 1'b0;
         m_axi_wready  <= 1'b0;
         m_axi_bvalid  <= 1'b0;
         m_axi_bid     <= '0;
         wBusy         <= 1'b0;
         waddr         <= '0;
         wlen          <= '0;
         wid           <= '0;
         wcnt          <= '0;
      end else begin
         if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
         if (!wBusy && !m_axi_bvalid) begin
            m_axi_awready <= 1'($urandom_range(1));
            if (m_axi_awvalid && m_axi_awready) begin
               wBusy         <= 1'b1;
               m_axi_awready <= 1'b0;
               m_axi_wready  <= 1'b0;
               waddr         <= m_axi_awaddr[15:2];
               wlen          <= m_axi_awlen;
               wid           <= m_axi_awid;
               wcnt          <= '0;
            end
         end else if (wBusy) begin
            m_axi_wready <= slaveGo();
            if (m_axi_wvalid && m_axi_wready) begin
               for (int b = 0; b < 4; b++)
                  if (m_axi_wstrb[b]) mem[wIdx][8*b +: 8] <= m_axi_wdata[8*b +: 8];
               if (wcnt == wlen) begin
                  wBusy        <= 1'b0;
                  m_axi_wready <= 1'b0;
                  m_axi_bvalid <= 1'b1;
                  m_axi_bid    <= corruptBid ? ~wid : wid;
               end else begin
                  wcnt <= wcnt + 8'd1;
               end
            end
         end
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_axi_arready <= 1'b0;
         m_axi_rvalid  <= 1'b0;
         rBusy         <= 1'b0;
         raddr         <= '0;
         rlen          <= '0;
         rid           <= '0;
         rcnt          <= '0;
      end else if (!rBusy) begin
         m_axi_arready <= 1'($urandom_range(1));
         if (m_axi_arvalid && m_axi_arready) begin
            rBusy         <= 1'b1;
            m_axi_arready <= 1'b0;
            raddr         <= m_axi_araddr[15:2];
            rlen          <= m_axi_arlen;
            rid           <= m_axi_arid;
            rcnt          <= '0;
         end
      end else if (m_axi_rvalid && m_axi_rready) begin
         if (rcnt == rlen) begin
            m_axi_rvalid <= 1'b0;
            rBusy        <= 1'b0;
         end else begin
            rcnt         <= rcnt + 8'd1;
            m_axi_rvalid <= slaveGo();
         end
      end else if (!m_axi_rvalid) begin
         m_axi_rvalid <= slaveGo();
      end
   end

   // Write-channel monitor: ordering against AW and wlast position
   always @(negedge clk) begin
      if (rst_n) begin
         if (m_axi_awvalid) awCycles++;
         if (m_axi_wvalid) begin
            wCycles++;
            checkOutput("w_after_aw", 64'(wBusy), 64'd1);
         end
         if (m_axi_wvalid && m_axi_wready)
            checkOutput("wlast", 64'(m_axi_wlast), 64'(wcnt == wlen));
      end
   end

   // Read-stream monitor: in-order data against the scoreboard, stable while stalled
   logic        rdHeldPrev = 1'b0;
   logic [31:0] rdDataPrev = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         rdHeldPrev = 1'b0;
      end else begin
         if (rdHeldPrev) begin
            checkOutput("rd_valid_held", 64'(rd_valid), 64'd1);
            checkOutput("rd_data_held", 64'(rd_data), 64'(rdDataPrev));
         end
         if (rd_valid && rd_ready) begin
            checkOutput("rd_expected", 64'(rdQ.size() != 0), 64'd1);
            if (rdQ.size() != 0) begin
               rdExp = rdQ.pop_front();
               checkOutput("rd_data", 64'(rd_data), 64'(rdExp.data));
               checkOutput("rd_last", 64'(rd_last), 64'(rdExp.last));
            end
         end
         rdHeldPrev = rd_valid && !rd_ready;
         rdDataPrev = rd_data;
      end
   end

   // Completion monitor: pulse contents, single-cycle width, cmd_ready afterwards
   logic donePrev = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         donePrev = 1'b0;
      end else begin
         if (donePrev) begin
            checkOutput("done_one_cycle", 64'(done_valid), 64'd0);
            checkOutput("cmd_ready_after_done", 64'(cmd_ready), 64'd1);
         end
         if (done_valid) begin
            doneCount++;
            checkOutput("done_expected", 64'(doneQ.size() != 0), 64'd1);
            if (doneQ.size() != 0) begin
               doneExp = doneQ.pop_front();
               checkOutput("done_write", 64'(done_write), 64'(doneExp.wr));
               checkOutput("done_id", 64'(done_id), 64'(doneExp.id));
               checkOutput("done_resp", 64'(done_resp), 64'(doneExp.resp));
            end
         end
         donePrev = done_valid;
      end
   end

   // Presents one command and returns just after the accepting edge
   task automatic applyStimulus(input logic wr, input logic [15:0] addr, input logic [7:0] len,
                                input logic [7:0] id, input logic [1:0] resp);
      int guard = 0;
      doneQ.push_back('{wr: wr, id: id, resp: resp});
      doneTarget = doneCount + 1;
      cmd_valid  = 1'b1;
      cmd_write  = wr;
      cmd_addr   = addr;
      cmd_len    = len;
      cmd_id     = id;
      @(negedge clk);
      while (!cmd_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("cmd_ready", 64'(cmd_ready), 64'd1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic pushReadExpect(input logic [31:0] base, input int len, input int lastBeat);
      for (int i = 0; i <= len; i++)
         rdQ.push_back('{data: base + 32'(i), last: (i == lastBeat)});
   endtask

   task automatic driveWriteBeats(input int len, input logic [31:0] base, input int stallPct, input int abortAt);
      int   beat = 0;
      int   cycles = 0;
      logic hs;
      wr_valid = 1'b0;
      while (beat <= len && cycles < 5000 && beat != abortAt) begin
         if (!wr_valid) wr_valid = (int'($urandom_range(99)) >= stallPct);
         wr_data = base + 32'(beat);
         wr_strb = 4'hF;
         @(negedge clk);
         hs = wr_valid && wr_ready;
         @(posedge clk);
         #1;
         if (hs) begin
            beat++;
            wr_valid = 1'b0;
         end
         cycles++;
      end
      wr_valid = 1'b0;
      if (abortAt < 0) checkOutput("w_beats_sent", 64'(beat), 64'(len + 1));
   endtask

   task automatic waitDone();
      int cycles = 0;
      while (doneCount < doneTarget && cycles < 2000) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      checkOutput("done_seen", 64'(doneCount >= doneTarget), 64'd1);
   endtask

   task automatic readDrain(input int stallPct);
      int cycles = 0;
      rd_ready = (int'($urandom_range(99)) >= stallPct);
      while (doneCount < doneTarget && cycles < 5000) begin
         @(posedge clk);
         #1;
         rd_ready = (int'($urandom_range(99)) >= stallPct);
         cycles++;
      end
      rd_ready = 1'b0;
      checkOutput("read_done_seen", 64'(doneCount >= doneTarget), 64'd1);
      checkOutput("rd_beats_left", 64'(rdQ.size()), 64'd0);
   endtask

   int aw0, w0;

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_len   = '0;
      cmd_id    = '0;
      wr_data   = '0;
      wr_strb   = '0;
      wr_valid  = 1'b0;
      rd_ready  = 1'b0;
      #2;
      checkOutput("reset_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                                        m_axi_rready, wr_ready, rd_valid, done_valid}), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("reset_cmd_ready", 64'(cmd_ready), 64'd1);
      checkOutput("reset_awaddr", 64'(m_axi_awaddr), 64'd0);
      @(posedge clk);
      #1;

      $display("[TB] single-beat write and read-back");
      applyStimulus(1'b1, 16'h0010, 8'd0, 8'h11, RESP_OKAY);
      checkOutput("aw_latency", 64'(m_axi_awvalid), 64'd1);
      checkOutput("awaddr", 64'(m_axi_awaddr), 64'h10);
      checkOutput("awlen", 64'(m_axi_awlen), 64'd0);
      checkOutput("awsize", 64'(m_axi_awsize), 64'd2);
      checkOutput("awburst", 64'(m_axi_awburst), 64'd1);
      checkOutput("awid", 64'(m_axi_awid), 64'h11);
      driveWriteBeats(0, 32'hDEADBEEF, 0, -1);
      waitDone();
      pushReadExpect(32'hDEADBEEF, 0, 0);
      applyStimulus(1'b0, 16'h0010, 8'd0, 8'h12, RESP_OKAY);
      checkOutput("ar_latency", 64'(m_axi_arvalid), 64'd1);
      checkOutput("arlen", 64'(m_axi_arlen), 64'd0);
      readDrain(0);

      $display("[TB] 256-beat write and read-back");
      applyStimulus(1'b1, 16'h0000, 8'd255, 8'h21, RESP_OKAY);
      driveWriteBeats(255, 32'hA5000000, 0, -1);
      waitDone();
      pushReadExpect(32'hA5000000, 255, 255);
      applyStimulus(1'b0, 16'h0000, 8'd255, 8'h22, RESP_OKAY);
      readDrain(0);

      $display("[TB] back-pressure on both streams");
      slaveStall = 1'b1;
      applyStimulus(1'b1, 16'h0400, 8'd15, 8'h31, RESP_OKAY);
      driveWriteBeats(15, 32'h10000000, 50, -1);
      waitDone();
      pushReadExpect(32'h10000000, 15, 15);
      applyStimulus(1'b0, 16'h0400, 8'd15, 8'h32, RESP_OKAY);
      readDrain(50);

      $display("[TB] 4 KB crossing");
      aw0 = awCycles;
      w0  = wCycles;
      applyStimulus(1'b1, 16'h0FF8, 8'd3, 8'h44, RESP_SLVERR);
      checkOutput("x4k_done_next", 64'(done_valid), 64'd1);
      checkOutput("x4k_no_awvalid", 64'(m_axi_awvalid), 64'd0);
      waitDone();
      checkOutput("x4k_aw_cycles", 64'(awCycles), 64'(aw0));
      checkOutput("x4k_w_cycles", 64'(wCycles), 64'(w0));

      $display("[TB] mismatched bid");
      corruptBid = 1'b1;
      applyStimulus(1'b1, 16'h0050, 8'd0, 8'h55, RESP_SLVERR);
      driveWriteBeats(0, 32'h12345678, 0, -1);
      waitDone();
      corruptBid = 1'b0;

      $display("[TB] early rlast");
      badRlastBeat = 2;
      pushReadExpect(32'h10000000, 3, 2);
      applyStimulus(1'b0, 16'h0400, 8'd3, 8'h66, RESP_SLVERR);
      readDrain(0);
      badRlastBeat = -1;

      $display("[TB] reset in the middle of a write");
      slaveStall = 1'b0;
      applyStimulus(1'b1, 16'h0800, 8'd15, 8'h33, RESP_OKAY);
      driveWriteBeats(15, 32'h20000000, 0, 5);
      wr_valid = 1'b1;
      #1;
      checkOutput("pre_reset_wvalid", 64'(m_axi_wvalid), 64'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("mid_reset_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                                            m_axi_rready, wr_ready, rd_valid, done_valid}), 64'd0);
      doneQ.delete();
      wr_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("post_reset_cmd_ready", 64'(cmd_ready), 64'd1);
      @(posedge clk);
      #1;
      applyStimulus(1'b1, 16'h0040, 8'd0, 8'h77, RESP_OKAY);
      driveWriteBeats(0, 32'hCAFEF00D, 0, -1);
      waitDone();
      pushReadExpect(32'hCAFEF00D, 0, 0);
      applyStimulus(1'b0, 16'h0040, 8'd0, 8'h78, RESP_OKAY);
      readDrain(0);

      repeat (3) @(posedge clk);
      #1;
      checkOutput("done_queue_empty", 64'(doneQ.size()), 64'd0);
      $display("%0d/%0d checks passed", checkPassed, checkTotal);
      $finish;
   end

endmodule
